// File: rtl/pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_ctrl
// Description : PLL reset sequencer and lock qualifier. Pulses the PLL reset,
//               waits for a synchronized lock, requires the lock to stay
//               stable for a programmed time before releasing the system
//               reset, and restarts the sequence on lock loss or timeout.
//               Optional retry limit: define PLL_RST_CTRL_RETRY_LIMIT_EN to
//               enter a sticky FAIL state after MAX_RETRIES consecutive
//               lock timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_i,
    input  logic       req_reset_i,
    output logic       pll_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [7:0] retry_cnt_o,
    output logic       fail_o
);

    // State encoding
    localparam logic [2:0] c_ST_PLL_RST   = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_STABLE    = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_FAIL      = 3'd4;

    // Terminal counts (the counter starts at 0 on every state entry)
    localparam logic [15:0] c_RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] c_STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] c_CNT_MAX      = 16'hFFFF;
    localparam logic [7:0]  c_RETRY_MAX    = 8'hFF;

`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
    localparam logic [7:0]  c_MAX_RETRIES  = 8'(MAX_RETRIES);
`else
    // The retry limit only exists when the FAIL state is built in.
    localparam int          c_unused_max_retries = MAX_RETRIES;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic        r_sync_meta;
    logic        r_locked_s;
    logic [7:0]  r_retry_cnt;
    logic [7:0]  w_retry_nxt;
    logic [7:0]  w_retry_inc;
    logic        w_lock_lost;
    logic        r_pll_rst;
    logic        r_sys_rst;
    logic        r_ready;
    logic        r_lock_lost;

    // Two-flop lock synchronizer. It is held clear while the PLL is in reset
    // so that a stale lock from before the reset pulse is never trusted; the
    // lock must be observed afresh after the PLL reset is released.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_locked_s  <= 1'b0;
        end else if (r_pll_rst) begin
            r_sync_meta <= 1'b0;
            r_locked_s  <= 1'b0;
        end else begin
            r_sync_meta <= locked_i;
            r_locked_s  <= r_sync_meta;
        end
    end

    // Next-state, retry-count and lock-loss decode; software request wins
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry_cnt;
        w_lock_lost = 1'b0;
        w_retry_inc = (r_retry_cnt == c_RETRY_MAX) ? c_RETRY_MAX : r_retry_cnt + 8'd1;

        if (req_reset_i) begin
            w_state_nxt = c_ST_PLL_RST;
            w_retry_nxt = 8'd0;
        end else begin
            case (r_state)
                c_ST_PLL_RST: begin
                    if (r_cnt == c_RST_LAST) begin
                        w_state_nxt = c_ST_WAIT_LOCK;
                    end
                end
                c_ST_WAIT_LOCK: begin
                    if (r_locked_s) begin
                        w_state_nxt = c_ST_STABLE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = c_ST_PLL_RST;
`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
                        if (w_retry_inc == c_MAX_RETRIES) begin
                            w_state_nxt = c_ST_FAIL;
                        end
`endif
                    end
                end
                c_ST_STABLE: begin
                    // Lock drop outranks completion on the same cycle
                    if (!r_locked_s) begin
                        w_state_nxt = c_ST_WAIT_LOCK;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        w_state_nxt = c_ST_RUN;
                        w_retry_nxt = 8'd0;
                    end
                end
                c_ST_RUN: begin
                    if (!r_locked_s) begin
                        w_state_nxt = c_ST_PLL_RST;
                        w_lock_lost = 1'b1;
                    end
                end
                c_ST_FAIL: begin
                    w_state_nxt = c_ST_FAIL;
                end
                default: begin
                    w_state_nxt = c_ST_PLL_RST;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_PLL_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shared cycle counter: cleared on every state change and on a software
    // restart (which restarts the count even when already in PLL_RST)
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else if ((w_state_nxt != r_state) || req_reset_i) begin
            r_cnt <= 16'd0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Registered outputs decoded from the next state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_retry_cnt <= 8'd0;
        end else begin
            r_pll_rst   <= (w_state_nxt == c_ST_PLL_RST) || (w_state_nxt == c_ST_FAIL);
            r_sys_rst   <= (w_state_nxt != c_ST_RUN);
            r_ready     <= (w_state_nxt == c_ST_RUN);
            r_lock_lost <= w_lock_lost;
            r_retry_cnt <= w_retry_nxt;
        end
    end

`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
    logic r_fail;

    // Sticky failure flag, set on the edge that enters FAIL
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_fail <= 1'b0;
        end else begin
            r_fail <= (w_state_nxt == c_ST_FAIL);
        end
    end

    assign fail_o = r_fail;
`else
    assign fail_o = 1'b0;
`endif

    assign pll_rst_o   = r_pll_rst;
    assign sys_rst_o   = r_sys_rst;
    assign ready_o     = r_ready;
    assign lock_lost_o = r_lock_lost;
    assign retry_cnt_o = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_ctrl
// Description : Self-checking bench for pll_reset_ctrl. Expected edge
//               positions are derived arithmetically from the sequencing
//               rules (reset pulse length, 2-flop sync, stable time,
//               timeout period) for randomized lock-drop patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_ctrl;

    localparam int RST_C  = 4;
    localparam int TO_C   = 20;
    localparam int STB_C  = 8;
    localparam int MAXR_C = 2;
    localparam int PER_C  = RST_C + TO_C;   // retry period with lock held low
`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
    localparam int NTO_C  = MAXR_C;
`else
    localparam int NTO_C  = 260;
`endif

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_i = 1'b1;
    logic       req_reset_i = 1'b0;
    logic       pll_rst_o;
    logic       sys_rst_o;
    logic       ready_o;
    logic       lock_lost_o;
    logic [7:0] retry_cnt_o;
    logic       fail_o;

    int n_tests = 0;
    int n_fail  = 0;

    pll_reset_ctrl #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TO_C),
        .STABLE_CYCLES(STB_C),
        .MAX_RETRIES  (MAXR_C)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked_i   (locked_i),
        .req_reset_i(req_reset_i),
        .pll_rst_o  (pll_rst_o),
        .sys_rst_o  (sys_rst_o),
        .ready_o    (ready_o),
        .lock_lost_o(lock_lost_o),
        .retry_cnt_o(retry_cnt_o),
        .fail_o     (fail_o)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_pll_rst"}, pll_rst_o, 1'b1);
        chk1({tag, "_sys_rst"}, sys_rst_o, 1'b1);
        chk1({tag, "_ready"}, ready_o, 1'b0);
        chk1({tag, "_lock_lost"}, lock_lost_o, 1'b0);
        chk8({tag, "_retry"}, retry_cnt_o, 8'd0);
        chk1({tag, "_fail"}, fail_o, 1'b0);
    endtask

    // Reference: lock loss seen at edge 3 (2 sync + 1 FSM), PLL reset for
    // RST_C edges, then lock must be re-observed through the synchronizer
    // (no earlier than the first edge after the PLL reset is released),
    // one edge into STABLE and STB_C edges of stable time.
    function automatic int relock_run_edge(input int d);
        int wl;
        int s1;
        wl = 3 + RST_C;
        s1 = (d + 1 > wl + 1) ? d + 1 : wl + 1;
        return s1 + 2 + STB_C;
    endfunction

    // Release rst with lock high and check the best-case bring-up
    task automatic release_check();
        rst = 1'b0;
        for (int k = 1; k <= RST_C + 3 + STB_C; k++) begin
            tick();
            chk1("boot_pll_rst", pll_rst_o, k < RST_C);
            chk1("boot_ready", ready_o, k >= RST_C + 3 + STB_C);
            chk1("boot_sys_rst", sys_rst_o, k < RST_C + 3 + STB_C);
            chk1("boot_lock_lost", lock_lost_o, 1'b0);
        end
    endtask

    // From RUN: drop lock, restore it after edge d, expect full recovery
    task automatic lock_loss(input int d);
        int t;
        t = relock_run_edge(d);
        locked_i = 1'b0;
        for (int k = 1; k <= t; k++) begin
            tick();
            if (k == d) locked_i = 1'b1;
            chk1("lost_pulse", lock_lost_o, k == 3);
            chk1("lost_sys_rst", sys_rst_o, (k >= 3) && (k < t));
            chk1("lost_pll_rst", pll_rst_o, (k >= 3) && (k < 3 + RST_C));
            chk1("lost_ready", ready_o, (k < 3) || (k >= t));
        end
        chk8("lost_retry", retry_cnt_o, 8'd0);
    endtask

    // From RUN: re-enter STABLE, then drop lock for 3 cycles at stable count c
    task automatic stable_glitch(input int c);
        int se;
        int t;
        se = relock_run_edge(2) - STB_C;
        t  = se + c + 6 + STB_C;
        locked_i = 1'b0;
        for (int k = 1; k <= t; k++) begin
            tick();
            if (k == 2) locked_i = 1'b1;
            if (k == se + c) locked_i = 1'b0;
            if (k == se + c + 3) locked_i = 1'b1;
            chk1("stb_ready", ready_o, (k < 3) || (k >= t));
            chk1("stb_pll_rst", pll_rst_o, (k >= 3) && (k < 3 + RST_C));
            chk1("stb_sys_rst", sys_rst_o, (k >= 3) && (k < t));
            chk8("stb_retry", retry_cnt_o, 8'd0);
        end
    endtask

    initial begin
        int nrand;
        int t;

        // Reset values while rst is held
        repeat (3) tick();
        chk_reset_vals("rst_hold");

        // Best-case bring-up
        release_check();

        // Randomized lock losses in RUN
        for (int i = 0; i < 4; i++) begin
            nrand = $urandom_range(1, 6);
            for (int k = 0; k < nrand; k++) begin
                tick();
                chk1("run_ready", ready_o, 1'b1);
            end
            lock_loss($urandom_range(2, 15));
        end

        // STABLE interrupted at count 5 (coincides with completion edge),
        // then at a random count
        stable_glitch(5);
        stable_glitch($urandom_range(0, 5));

        // Software request on the lock-loss edge, then again mid PLL_RST
        locked_i = 1'b0;
        tick();
        tick();
        req_reset_i = 1'b1;
        tick();
        req_reset_i = 1'b0;
        locked_i = 1'b1;
        chk1("req_lost_pulse", lock_lost_o, 1'b0);
        chk1("req_pll_rst", pll_rst_o, 1'b1);
        chk1("req_sys_rst", sys_rst_o, 1'b1);
        chk1("req_ready", ready_o, 1'b0);
        tick();
        req_reset_i = 1'b1;
        tick();
        req_reset_i = 1'b0;
        for (int k = 6; k <= 20; k++) begin
            tick();
            chk1("req_restart_pll_rst", pll_rst_o, k < 9);
            chk1("req_restart_ready", ready_o, k >= 20);
            chk1("req_restart_lost", lock_lost_o, 1'b0);
        end

        // Lock held low: periodic retries
        locked_i = 1'b0;
        for (int k = 1; k <= 3 + PER_C * NTO_C; k++) begin
            tick();
            if ((k > 3) && ((k - 3) % PER_C == 0)) begin
                t = (k - 3) / PER_C;
                chk8("to_retry", retry_cnt_o, (t > 255) ? 8'd255 : 8'(t));
                chk1("to_pll_rst", pll_rst_o, 1'b1);
            end
            if ((k > 3) && ((k - 2) % PER_C == 0)) begin
                t = (k - 2) / PER_C - 1;
                chk8("to_retry_pre", retry_cnt_o, (t > 255) ? 8'd255 : 8'(t));
                chk1("to_pll_rst_pre", pll_rst_o, 1'b0);
            end
`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
            chk1("to_fail", fail_o, k >= 3 + PER_C * MAXR_C);
`else
            if (k % 500 == 0) chk1("to_fail_tied", fail_o, 1'b0);
`endif
        end
        // Hold position: FAIL is sticky, otherwise keep retrying
        for (int k = 0; k < 10 + RST_C; k++) begin
            tick();
`ifdef PLL_RST_CTRL_RETRY_LIMIT_EN
            chk1("fail_hold", fail_o, 1'b1);
            chk1("fail_pll_rst", pll_rst_o, 1'b1);
            chk1("fail_sys_rst", sys_rst_o, 1'b1);
            chk8("fail_retry", retry_cnt_o, 8'(MAXR_C));
`else
            chk1("nofail_hold", fail_o, 1'b0);
            chk8("sat_retry", retry_cnt_o, 8'd255);
`endif
        end
        req_reset_i = 1'b1;
        tick();
        req_reset_i = 1'b0;
        locked_i = 1'b1;
        chk1("clr_fail", fail_o, 1'b0);
        chk8("clr_retry", retry_cnt_o, 8'd0);
        chk1("clr_pll_rst", pll_rst_o, 1'b1);
        for (int k = 1; k <= RST_C + 3 + STB_C; k++) begin
            tick();
            chk1("clr_pll_rst_seq", pll_rst_o, k < RST_C);
            chk1("clr_ready", ready_o, k >= RST_C + 3 + STB_C);
        end

        // Asynchronous reset in the middle of STABLE
        locked_i = 1'b0;
        tick();
        tick();
        locked_i = 1'b1;
        for (int k = 3; k <= relock_run_edge(2) - STB_C + 2; k++) tick();
        chk1("pre_arst_pll_rst", pll_rst_o, 1'b0);
        chk1("pre_arst_sys_rst", sys_rst_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("arst_async");
        tick();
        tick();
        chk_reset_vals("arst_hold");
        release_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

PLL reset sequencer and lock qualifier for the SoC clocking subsystem. Runs on the PLL reference clock, drives the PLL `rst` input, and watches the PLL `locked` output. It produces a system reset that is released only after lock has been stable for a programmed time. Loss of lock is handled by re-asserting system reset and re-running the PLL reset, and a lock timeout triggers a retry.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_rst_o` is held high per PLL reset pulse (1..65535).
- `LOCK_TIMEOUT`, 1000: cycles allowed in WAIT_LOCK before a retry (1..65535).
- `STABLE_CYCLES`, 64: consecutive synchronized-locked cycles required before release (1..65535).
- `MAX_RETRIES`, 4: consecutive timeouts before FAIL. Used only with the retry-limit macro (1..255).

Ports:
- `refclk`, in, 1: sole clock, the free-running PLL reference clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `locked_i`, in, 1: PLL `locked`; asynchronous to `refclk`.
- `req_reset_i`, in, 1: single-cycle software request to restart the sequence.
- `pll_rst_o`, out, 1: connects to PLL `rst`.
- `sys_rst_o`, out, 1: active-high reset for logic clocked by the PLL outputs.
- `ready_o`, out, 1: high in RUN only.
- `lock_lost_o`, out, 1: one-cycle pulse on loss of lock in RUN.
- `retry_cnt_o`, out, 8: consecutive lock timeouts since the last RUN entry; saturates at 255.
- `fail_o`, out, 1: retry limit exhausted. Tied 0 without the retry-limit macro.

## Operation
- `locked_i` passes through a 2-FF synchronizer to `locked_s`; FSM decisions use `locked_s` only.
- A single 16-bit cycle counter `cnt` is cleared on every state change.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state.

States:
- **PLL_RST**: `pll_rst_o`=1, `sys_rst_o`=1. When `cnt` = RST_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK**:
  - `pll_rst_o`=0, `sys_rst_o`=1.
  - If `locked_s`=1, go to STABLE.
  - Else, when `cnt` = LOCK_TIMEOUT-1: increment `retry_cnt_o` (saturating) and go to PLL_RST.
- **STABLE**:
  - `sys_rst_o`=1.
  - If `locked_s`=0, go to WAIT_LOCK with no retry increment.
  - Else, when `cnt` = STABLE_CYCLES-1, go to RUN.
- **RUN**:
  - `sys_rst_o`=0, `ready_o`=1, `retry_cnt_o` cleared on entry.
  - If `locked_s`=0: pulse `lock_lost_o`, set `sys_rst_o`=1 on the same edge, go to PLL_RST.
- **FAIL** (macro only): `pll_rst_o`=1, `sys_rst_o`=1, `fail_o`=1. Held until `rst` or `req_reset_i`.

Priority and boundaries:
- `req_reset_i`=1 in any state forces PLL_RST with `cnt`=0 and clears `retry_cnt_o` and `fail_o`. It takes priority over timeout, lock loss and stable completion on the same cycle, and `lock_lost_o` stays 0 in that case.
- `req_reset_i` in PLL_RST restarts the RST_CYCLES count.
- A lock glitch shorter than 2 cycles may be missed by the synchronizer. This is acceptable because the PLL holds `locked` low for much longer than that.

## Timing
Reset values:
- State PLL_RST, `cnt`=0, synchronizer=0.
- `pll_rst_o`=1, `sys_rst_o`=1, `ready_o`=0, `lock_lost_o`=0, `retry_cnt_o`=0, `fail_o`=0.

Latencies:
- After `rst` deasserts, `pll_rst_o` stays high for exactly RST_CYCLES rising edges.
- `locked_i` rise to STABLE entry: 3 edges (2 synchronizer edges + 1 FSM edge).
- Best-case `rst` release to `ready_o`=1: RST_CYCLES + 3 + STABLE_CYCLES edges, if `locked_i` is high from the first WAIT_LOCK cycle.
- `locked_i` fall in RUN to `sys_rst_o`=1: 3 edges.

## Configuration
- `PLL_RST_CTRL_RETRY_LIMIT_EN` defined:
  - A timeout that makes `retry_cnt_o` equal MAX_RETRIES goes to FAIL instead of PLL_RST.
  - `fail_o` is asserted on that same edge.
- `PLL_RST_CTRL_RETRY_LIMIT_EN` undefined:
  - Retries continue indefinitely and FAIL is unreachable.
  - `fail_o` is constant 0 and MAX_RETRIES is ignored.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Release `rst`, hold `locked_i`=1 -> `pll_rst_o` high for 4 edges; `ready_o`=1 and `sys_rst_o`=0 at edge 4+3+8=15.
- Drop `locked_i` in RUN -> `lock_lost_o` pulses once and `sys_rst_o`=1 three edges later; `pll_rst_o`=1 for 4 edges; re-lock then reaches RUN again.
- Hold `locked_i`=0 -> `pll_rst_o` re-pulses every 24 edges with `retry_cnt_o` 1, 2. With the macro: FAIL and `fail_o`=1 after the 2nd timeout. Without it: `retry_cnt_o` keeps incrementing and saturates at 255.
- In STABLE, drop `locked_i` for 3 cycles at `cnt`=5 -> return to WAIT_LOCK, `retry_cnt_o` unchanged; after re-lock, STABLE restarts from 0 and needs a full 8 cycles.
- Assert `req_reset_i` in FAIL, and separately on the same cycle as a lock drop in RUN -> PLL_RST, `retry_cnt_o`=0, `fail_o`=0, `lock_lost_o` stays 0.
- Assert `rst` mid-STABLE -> all outputs take reset values asynchronously, before the next `refclk` edge.
